// File: rtl/jt51_lfo_pkg.sv
// Shared encodings and the waveform shaper for the JT51 PM LFO.
// Noise source is built only when JT51_PM_LFO_NOISE_EN is defined.
package jt51_lfo_pkg;

  localparam int          ACC_W_DEF = 20;
  localparam logic [14:0] SEED_DEF  = 15'h7FFF;
  localparam int          PM_SHIFT  = 5;
  localparam int          MUL_STEPS = 7;

  typedef enum logic [1:0] {
    LFO_SAW = 2'd0,
    LFO_SQR = 2'd1,
    LFO_TRI = 2'd2,
    LFO_NOI = 2'd3
  } lfo_wave_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } pm_state_e;

  typedef struct packed {
    logic [7:0] mag;
    logic       neg;
  } lfo_sample_t;

  // Signed 8-bit waveform value from phase, returned as magnitude + sign.
  // |-128| = 128 still fits the unsigned 8-bit magnitude.
  function automatic lfo_sample_t lfo_shape(input logic [1:0] w,
                                            input logic [7:0] p,
                                            input logic [7:0] noise);
    logic [7:0]  v;
    logic [7:0]  tri_v;
    logic [7:0]  f2;
    lfo_sample_t s;
    f2 = {1'b0, p[5:0], 1'b0};
    case (p[7:6])
      2'd0:    tri_v = f2;
      2'd1:    tri_v = 8'd126 - f2;
      2'd2:    tri_v = 8'd0 - f2;
      default: tri_v = f2 - 8'd126;
    endcase
    case (lfo_wave_e'(w))
      LFO_SAW: v = p ^ 8'h80;
      LFO_SQR: v = p[7] ? 8'h80 : 8'h7F;
      LFO_TRI: v = tri_v;
      default: v = noise;
    endcase
    s.neg = v[7];
    s.mag = v[7] ? (8'd0 - v) : v;
    return s;
  endfunction

endpackage

// File: rtl/jt51_pm_lfo_mul.sv
// 8x7 serial shift-add multiplier: one multiplier bit per cen, LSB first.
// start loads operands; done pulses (combinationally) on the final iteration.
module jt51_pm_lfo_mul
  import jt51_lfo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        abort,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [6:0]  mplier,
  output logic        done,
  output logic [13:0] prod
);

  logic        busy_q, busy_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [13:0] acc_q, acc_d;
  logic [13:0] mc_q, mc_d;
  logic [6:0]  mp_q, mp_d;
  logic [13:0] sum;
  logic        last;

  assign last = (cnt_q == 3'(MUL_STEPS - 1));
  assign sum  = acc_q + (mp_q[0] ? mc_q : 14'd0);
  assign done = cen & busy_q & ~abort & last;
  assign prod = sum;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mc_d   = mc_q;
    mp_d   = mp_q;
    if (cen) begin
      if (abort) begin
        busy_d = 1'b0;
      end else if (start) begin
        busy_d = 1'b1;
        cnt_d  = 3'd0;
        acc_d  = 14'd0;
        mc_d   = {6'd0, mcand};
        mp_d   = mplier;
      end else if (busy_q) begin
        acc_d = sum;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 3'd1;
        if (last) busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 3'd0;
      acc_q  <= 14'd0;
      mc_q   <= 14'd0;
      mp_q   <= 7'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mc_q   <= mc_d;
      mp_q   <= mp_d;
    end
  end

endmodule

// File: rtl/jt51_pm_lfo.sv
// JT51 PM LFO: prescaler, phase, optional noise LFSR (JT51_PM_LFO_NOISE_EN),
// waveform shaper and serial depth multiplier feeding the PM adder.
module jt51_pm_lfo
  import jt51_lfo_pkg::*;
#(
  parameter int          ACC_W = ACC_W_DEF,
  parameter logic [14:0] SEED  = SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       lfo_rst,
  input  logic [7:0] lfo_freq,
  input  logic [1:0] lfo_w,
  input  logic [6:0] lfo_pmd,
  output logic [8:0] pm_mod,
  output logic       pm_add,
  output logic       pm_upd
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_inc, acc_sum;
  logic [7:0]       phase_q, phase_d;
  logic             pending_q, pending_d;
  logic             sign_q, sign_d;
  logic [8:0]       pm_mod_q, pm_mod_d;
  logic             pm_add_q, pm_add_d;
  logic             pm_upd_q, pm_upd_d;
  pm_state_e        state_q, state_d;
  logic             step, capture, mul_done;
  logic [13:0]      mul_prod;
  logic [8:0]       mod_val;
  logic [7:0]       noise_byte;
  lfo_sample_t      smp;

  assign acc_inc = {{(ACC_W-4){1'b0}}, 1'b1, lfo_freq[3:0]} << lfo_freq[7:4];
  assign acc_sum = {1'b0, acc_q} + acc_inc;
  assign step    = cen & ~lfo_rst & acc_sum[ACC_W];

`ifdef JT51_PM_LFO_NOISE_EN
  logic [14:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (cen) begin
      if (lfo_rst)   lfsr_d = SEED;
      else if (step) lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign noise_byte = lfsr_q[7:0];
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
  assign noise_byte  = 8'h00;
`endif

  // Shaper reads the registered phase; capture happens one cen after the step.
  assign smp     = lfo_shape(lfo_w, phase_q, noise_byte);
  assign mod_val = 9'(mul_prod >> PM_SHIFT);

  jt51_pm_lfo_mul u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .abort  (lfo_rst),
    .start  (capture),
    .mcand  (smp.mag),
    .mplier (lfo_pmd),
    .done   (mul_done),
    .prod   (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cen) begin
      if (lfo_rst) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (pending_q) state_d = ST_MUL;
          ST_MUL:  if (mul_done)  state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    capture = cen & ~lfo_rst & (state_q == ST_IDLE) & pending_q;
  end

  // Pending is a single flag, so several steps during one multiply coalesce.
  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    sign_d    = sign_q;
    pm_mod_d  = pm_mod_q;
    pm_add_d  = pm_add_q;
    pm_upd_d  = 1'b0;
    if (cen) begin
      if (lfo_rst) begin
        acc_d     = '0;
        phase_d   = 8'd0;
        pending_d = 1'b0;
        pm_mod_d  = 9'd0;
        pm_add_d  = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
        if (step) phase_d = phase_q + 8'd1;
        if (step)         pending_d = 1'b1;
        else if (capture) pending_d = 1'b0;
        if (capture) sign_d = smp.neg;
        if (mul_done) begin
          pm_mod_d = mod_val;
          pm_add_d = ~sign_q | (mod_val == 9'd0);
          pm_upd_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      phase_q   <= 8'd0;
      pending_q <= 1'b0;
      sign_q    <= 1'b0;
      pm_mod_q  <= 9'd0;
      pm_add_q  <= 1'b1;
      pm_upd_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      sign_q    <= sign_d;
      pm_mod_q  <= pm_mod_d;
      pm_add_q  <= pm_add_d;
      pm_upd_q  <= pm_upd_d;
    end
  end

  assign pm_mod = pm_mod_q;
  assign pm_add = pm_add_q;
  assign pm_upd = pm_upd_q;

endmodule

// File: tb/tb_jt51_pm_lfo.sv
// Bench for jt51_pm_lfo: vector table + per-step scoreboard + corner sequences.
module tb_jt51_pm_lfo;

  logic       clk = 1'b0;
  logic       rst_n, cen, lfo_rst;
  logic [7:0] lfo_freq;
  logic [1:0] lfo_w;
  logic [6:0] lfo_pmd;
  logic [8:0] pm_mod;
  logic       pm_add, pm_upd;

  jt51_pm_lfo dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .lfo_rst(lfo_rst),
    .lfo_freq(lfo_freq), .lfo_w(lfo_w), .lfo_pmd(lfo_pmd),
    .pm_mod(pm_mod), .pm_add(pm_add), .pm_upd(pm_upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] w;
    logic [6:0] pmd;
    logic       rnd_cen;
    int         nsteps;
    int         exp_mod;
    int         exp_add;
  } vec_t;

  typedef struct {
    int mod;
    int add;
    int due;
  } sb_t;

  vec_t tbl[6];
  sb_t  q[$];
  int   n_pass = 0, n_chk = 0;
  int   macc, mph, mlfsr, ncen;
  bit   m_step, sb_en;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void model_exp(input int w, input int p, input int lb, input int pmd,
                                    output int mod, output int add);
    int v, m, f;
    f = p % 64;
    case (w)
      0: v = p - 128;
      1: v = (p >= 128) ? -128 : 127;
      2: case (p / 64)
           0: v = 2 * f;
           1: v = 126 - 2 * f;
           2: v = -2 * f;
           default: v = 2 * f - 126;
         endcase
`ifdef JT51_PM_LFO_NOISE_EN
      default: v = (lb >= 128) ? lb - 256 : lb;
`else
      default: v = 0;
`endif
    endcase
    m   = (v < 0) ? -v : v;
    mod = (m * pmd) / 32;
    add = (mod == 0) ? 1 : ((v >= 0) ? 1 : 0);
  endfunction

  // One clock: model the edge with the inputs that were applied, then check.
  task automatic cyc();
    logic       e_cen, e_rst, e_lrst;
    logic [7:0] e_freq;
    logic [1:0] e_w;
    logic [6:0] e_pmd;
    int         mod, add;
    sb_t        e;
    e_cen = cen; e_rst = rst_n; e_lrst = lfo_rst;
    e_freq = lfo_freq; e_w = lfo_w; e_pmd = lfo_pmd;
    @(posedge clk); #1;
    m_step = 1'b0;
    if (!e_rst) begin
      macc = 0; mph = 0; mlfsr = 'h7FFF; q.delete();
    end else if (e_cen) begin
      ncen++;
      if (e_lrst) begin
        macc = 0; mph = 0; mlfsr = 'h7FFF; q.delete();
      end else begin
        macc += (16 + int'(e_freq[3:0])) << int'(e_freq[7:4]);
        if (macc >= (1 << 20)) begin
          macc  -= (1 << 20);
          mph    = (mph + 1) % 256;
          mlfsr  = ((mlfsr << 1) | (((mlfsr >> 14) ^ (mlfsr >> 13)) & 1)) & 'h7FFF;
          m_step = 1'b1;
          if (sb_en) begin
            model_exp(int'(e_w), mph, mlfsr & 'hFF, int'(e_pmd), mod, add);
            e.mod = mod; e.add = add; e.due = ncen + 8;
            q.push_back(e);
          end
        end
      end
    end
    if (pm_upd) chk("upd_single_clk", int'(e_cen), 1);
    if (sb_en) begin
      if (pm_upd) begin
        if (q.size() == 0) chk("sb_unexpected_upd", int'(pm_upd), 0);
        else begin
          e = q.pop_front();
          chk("sb_mod", int'(pm_mod), e.mod);
          chk("sb_add", int'(pm_add), e.add);
          chk("sb_latency", ncen, e.due);
        end
      end else if (q.size() > 0 && q[0].due < ncen) begin
        chk("sb_missing_upd", ncen, q[0].due);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic wait_upd(input int bound);
    int n = 0;
    do begin cyc(); n++; end while (!pm_upd && n < bound);
  endtask

  task automatic wait_step(input int bound);
    int n = 0;
    do begin cyc(); n++; end while (!m_step && n < bound);
    chk("step_seen", int'(m_step), 1);
  endtask

  task automatic restart(input logic [1:0] w, input logic [6:0] pmd, input logic [7:0] f);
    lfo_w = w; lfo_pmd = pmd; lfo_freq = f; cen = 1'b1;
    lfo_rst = 1'b1; cyc(); lfo_rst = 1'b0;
  endtask

  initial begin
    int cnt;
    tbl[0] = '{2'd0, 7'd64,  1'b0, 260, 254, 0};
    tbl[1] = '{2'd1, 7'd127, 1'b0, 20,  504, 1};
    tbl[2] = '{2'd2, 7'd100, 1'b0, 260, 6,   1};
    tbl[3] = '{2'd0, 7'd0,   1'b0, 10,  0,   1};
`ifdef JT51_PM_LFO_NOISE_EN
    tbl[4] = '{2'd3, 7'd127, 1'b0, 40,  7,   0};
`else
    tbl[4] = '{2'd3, 7'd127, 1'b0, 40,  0,   1};
`endif
    tbl[5] = '{2'd2, 7'd127, 1'b1, 30,  7,   1};

    rst_n = 1'b0; cen = 1'b1; lfo_rst = 1'b0; lfo_freq = 8'hC8;
    lfo_w = 2'd0; lfo_pmd = 7'd0; sb_en = 1'b0; ncen = 0;
    macc = 0; mph = 0; mlfsr = 'h7FFF; m_step = 1'b0;
    repeat (3) cyc();
    chk("rst_mod", int'(pm_mod), 0);
    chk("rst_add", int'(pm_add), 1);
    chk("rst_upd", int'(pm_upd), 0);
    rst_n = 1'b1;

    sb_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n;
      restart(tbl[i].w, tbl[i].pmd, 8'hC8);
      chk("lrst_mod", int'(pm_mod), 0);
      chk("lrst_add", int'(pm_add), 1);
      chk("lrst_upd", int'(pm_upd), 0);
      n = 0;
      do begin
        cen = tbl[i].rnd_cen ? ($urandom_range(0, 1) != 0) : 1'b1;
        cyc(); n++;
      end while (!pm_upd && n < 400);
      chk("vec_upd", int'(pm_upd), 1);
      chk("vec_mod", int'(pm_mod), tbl[i].exp_mod);
      chk("vec_add", int'(pm_add), tbl[i].exp_add);
      repeat (tbl[i].nsteps * 12) begin
        cen = tbl[i].rnd_cen ? ($urandom_range(0, 1) != 0) : 1'b1;
        cyc();
      end
    end

    // lfo_rst on the 3rd multiply iteration aborts the run silently
    restart(2'd0, 7'd64, 8'hC8);
    wait_upd(100);
    chk("abort_pre_mod", int'(pm_mod), 254);
    wait_step(100);
    repeat (3) cyc();
    lfo_rst = 1'b1; cyc(); lfo_rst = 1'b0;
    chk("abort_mod", int'(pm_mod), 0);
    chk("abort_add", int'(pm_add), 1);
    chk("abort_upd", int'(pm_upd), 0);
    cnt = 0;
    repeat (15) begin cyc(); if (pm_upd) cnt++; end
    chk("abort_no_upd", cnt, 0);
    wait_upd(40);
    chk("abort_restart_mod", int'(pm_mod), 254);
    chk("abort_restart_add", int'(pm_add), 0);

    // rst_n held 3 clocks mid-multiply, with cen low
    wait_step(100);
    repeat (3) cyc();
    rst_n = 1'b0; cen = 1'b0; cyc();
    chk("midrst_mod", int'(pm_mod), 0);
    chk("midrst_add", int'(pm_add), 1);
    chk("midrst_upd", int'(pm_upd), 0);
    cyc(); cyc();
    rst_n = 1'b1; cen = 1'b1;
    wait_upd(40);
    chk("midrst_phase0_mod", int'(pm_mod), 254);
    chk("midrst_phase0_add", int'(pm_add), 0);

    // fast square: coalesced steps and the negative half
    sb_en = 1'b0; q.delete();
    restart(2'd1, 7'd127, 8'hF0);
    wait_upd(40);
    chk("sqr_first_upd", int'(pm_upd), 1);
    chk("sqr_first_mod", int'(pm_mod), 504);
    chk("sqr_first_add", int'(pm_add), 1);
    repeat (4) cyc();
    lfo_freq = 8'h00;
    cnt = 0;
    repeat (60) begin cyc(); if (pm_upd) cnt++; end
    chk("coalesce_updates", cnt, 2);
    lfo_freq = 8'hF0;
    begin
      int n = 0;
      do begin cyc(); n++; end while (!(pm_upd && !pm_add) && n < 1500);
    end
    chk("sqr_neg_mod", int'(pm_mod), 508);
    chk("sqr_neg_add", int'(pm_add), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
